game_tempo_ctrl: RTL and testbench

Game-flow controller for the Drums Hero tempo path. It sequences the 32-pulse tempo divider by driving its `stop`, `nivel2` and `nivel3` controls. It also counts note hits and misses to promote difficulty level and end the game, and counts tempo ticks to detect song completion. It sits between the button/scoring logic and the tempo divider, and is the only block allowed to drive the divider's control inputs.

---
 rtl/game_tempo_pkg.sv | 15 +
 rtl/game_tempo_sync_edge.sv | 26 ++
 rtl/game_tempo_ctrl.sv | 143 ++++++++++++++
 tb/tb_game_tempo_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/game_tempo_pkg.sv
// Shared encodings for the Drums Hero game-flow controller.
package game_tempo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] LEVEL1 = 2'd1;
    localparam logic [1:0] LEVEL2 = 2'd2;
    localparam logic [1:0] LEVEL3 = 2'd3;

endpackage

// File: rtl/game_tempo_sync_edge.sv
// Brings the asynchronous tempo clock into the clk domain.
// It emits a one-cycle pulse on each rising edge of that clock.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/game_tempo_ctrl.sv
// Game-flow FSM for the tempo path. It drives the divider controls stop, nivel2 and nivel3.
// It counts hits, misses and tempo ticks to pick the level and to detect a win or a loss.
module game_tempo_ctrl
    import game_tempo_pkg::*;
#(
    parameter int LVL2_HITS  = 32,
    parameter int LVL3_HITS  = 64,
    parameter int MAX_MISS   = 8,
    parameter int SONG_TICKS = 4096,
    parameter int CNT_W      = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       hit,
    input  logic       miss,
    input  logic       tick32,
    output logic       stop,
    output logic       nivel2,
    output logic       nivel3,
    output logic [1:0] level,
    output logic [1:0] state,
    output logic       win,
    output logic [7:0] hits
);

    localparam int MISS_W = $clog2(MAX_MISS + 1);

    state_t            state_q, state_d;
    logic              stop_d, win_d, nivel2_d, nivel3_d, clear;
    logic [1:0]        level_d, pend_level;
    logic [7:0]        hits_d;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic [CNT_W-1:0]  tick_q, tick_d, tick_inc;
    logic              tick_p, counting, end_miss, end_song;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tick32),
        .pulse (tick_p)
    );

    assign counting = (state_q == ST_RUN);
    assign miss_inc = miss_q + MISS_W'(1);
    assign tick_inc = tick_q + CNT_W'(1);
    assign end_miss = counting && miss && (miss_inc == MISS_W'(MAX_MISS));
    assign end_song = counting && tick_p && (tick_inc == CNT_W'(SONG_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stop    <= 1'b1;
            win     <= 1'b0;
            level   <= LEVEL1;
            nivel2  <= 1'b0;
            nivel3  <= 1'b0;
            hits    <= 8'd0;
            miss_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            stop    <= stop_d;
            win     <= win_d;
            level   <= level_d;
            nivel2  <= nivel2_d;
            nivel3  <= nivel3_d;
            hits    <= hits_d;
            miss_q  <= miss_d;
            tick_q  <= tick_d;
        end
    end

    // The loss check comes before the song-end check, so a miss limit in the same cycle as the last tick gives a loss.
    always_comb begin
        state_d = state_q;
        win_d   = win;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (end_miss) begin
                    state_d = ST_OVER;
                    win_d   = 1'b0;
                end else if (end_song) begin
                    state_d = ST_OVER;
                    win_d   = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause) state_d = ST_RUN;
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                    win_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (int'(hits) >= LVL3_HITS)      pend_level = LEVEL3;
        else if (int'(hits) >= LVL2_HITS) pend_level = LEVEL2;
        else                              pend_level = LEVEL1;
    end

    // A level change waits for a tempo tick so that one divider period never mixes two speeds.
    always_comb begin
        stop_d  = (state_d != ST_RUN);
        hits_d  = hits;
        miss_d  = miss_q;
        tick_d  = tick_q;
        level_d = level;
        if (clear) begin
            hits_d  = 8'd0;
            miss_d  = '0;
            tick_d  = '0;
            level_d = LEVEL1;
        end else if (counting) begin
            if (hit && hits != 8'hff) hits_d = hits + 8'd1;
            if (miss)   miss_d = miss_inc;
            if (tick_p) tick_d = tick_inc;
            if (tick_p && state_d == ST_RUN && pend_level > level)
                level_d = pend_level;
        end
        nivel2_d = (level_d == LEVEL2);
        nivel3_d = (level_d == LEVEL3);
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_tempo_ctrl.sv
// Directed bench for game_tempo_ctrl. It runs a short song (SONG_TICKS=16) so a complete game fits in the run.
module tb_game_tempo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0, tick32 = 1'b0;
    logic       stop, nivel2, nivel3, win;
    logic [1:0] level, state;
    logic [7:0] hits;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_tempo_ctrl #(
        .LVL2_HITS  (32),
        .LVL3_HITS  (64),
        .MAX_MISS   (8),
        .SONG_TICKS (16),
        .CNT_W      (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .pause  (pause),
        .hit    (hit),
        .miss   (miss),
        .tick32 (tick32),
        .stop   (stop),
        .nivel2 (nivel2),
        .nivel3 (nivel3),
        .level  (level),
        .state  (state),
        .win    (win),
        .hits   (hits)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc(1); pause = 1'b0;
    endtask

    task automatic hit_n(input int n);
        hit = 1'b1; cyc(n); hit = 1'b0;
    endtask

    task automatic miss_n(input int n);
        miss = 1'b1; cyc(n); miss = 1'b0;
    endtask

    task automatic tick_edge();
        tick32 = 1'b1; cyc(3);
        tick32 = 1'b0; cyc(3);
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_state", state, 0);
        chk("rst_stop", stop, 1);
        chk("rst_nivel2", nivel2, 0);
        chk("rst_nivel3", nivel3, 0);
        chk("rst_level", level, 1);
        chk("rst_hits", hits, 0);
        chk("rst_win", win, 0);

        pulse_pause();
        chk("idle_pause_ignored", state, 0);
        pulse_start();
        chk("start_state", state, 1);
        chk("start_stop", stop, 0);

        hit_n(32);
        chk("hits32", hits, 32);
        chk("lvl_before_tick", level, 1);
        tick32 = 1'b1;
        cyc(2);
        chk("lvl_waits_tick", level, 1);
        cyc(1);
        chk("lvl2_level", level, 2);
        chk("lvl2_nivel2", nivel2, 1);
        chk("lvl2_nivel3", nivel3, 0);
        cyc(2);
        tick32 = 1'b0;
        cyc(3);

        pulse_pause();
        chk("pause_state", state, 2);
        chk("pause_stop", stop, 1);
        hit_n(5);
        repeat (100) tick_edge();
        chk("pause_hits_frozen", hits, 32);
        pulse_start();
        chk("pause_start_ignored", state, 2);
        pulse_pause();
        chk("resume_state", state, 1);
        chk("resume_stop", stop, 0);

        repeat (14) tick_edge();
        chk("tick15_still_run", state, 1);
        tick_edge();
        chk("song_end_state", state, 3);
        chk("song_end_win", win, 1);
        chk("song_end_stop", stop, 1);

        pulse_start();
        chk("restart_state", state, 1);
        chk("restart_level", level, 1);
        chk("restart_hits", hits, 0);
        chk("restart_win", win, 0);
        chk("restart_nivel2", nivel2, 0);

        miss_n(7);
        chk("miss7_run", state, 1);
        miss = 1'b1; hit = 1'b1;
        cyc(1);
        miss = 1'b0; hit = 1'b0;
        chk("miss8_state", state, 3);
        chk("miss8_win", win, 0);
        chk("miss8_stop", stop, 1);
        chk("miss8_hits", hits, 1);

        pulse_start();
        hit_n(64);
        chk("hits64", hits, 64);
        chk("lvl3_before_tick", level, 1);
        tick32 = 1'b1;
        cyc(3);
        chk("lvl3_level", level, 3);
        chk("lvl3_nivel3", nivel3, 1);
        chk("lvl3_nivel2", nivel2, 0);

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_stop", stop, 1);
        chk("async_rst_level", level, 1);
        chk("async_rst_nivel2", nivel2, 0);
        chk("async_rst_nivel3", nivel3, 0);
        chk("async_rst_hits", hits, 0);
        chk("async_rst_win", win, 0);
        tick32 = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
